gf2_31_prng_seq: RTL and testbench

Sequencer for the GF(2^31) PRNG datapath. It holds the PRNG state s(x) and produces the next value s'(x) = s(x)·g(x) mod h(x), with h(x) = x^31 + x^13 + x^8 + x^3 + 1 and g(x) a constant generator. The product is computed bit-serially, MSB-first by Horner's rule, with one reduction per cycle. This replaces a full-width multiplier followed by a wide combinational modular reduction. It sits between the seed/configuration interface and the random-word consumer.

---
 rtl/gf2_31_prng_seq.sv | 96 +++++++++
 tb/tb_gf2_31_prng_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/gf2_31_prng_seq.sv
// GF(2^31) PRNG sequencer: next state = state * MULT mod h(x), computed bit-serially
// MSB-first (Horner), one shift-and-reduce step per clock.
module gf2_31_prng_seq #(
  parameter int               WIDTH    = 31,
  parameter logic [WIDTH-1:0] POLY_LOW = 31'h0000_2109,
  parameter logic [WIDTH-1:0] MULT     = 31'h0000_0002
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic             ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] rand_out,
  output logic             seed_zero
);

  localparam int         CNT_W   = 5;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

  logic [0:0]       fsm_reg;
  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] rand_out_reg;
  logic             out_valid_reg;
  logic             seed_zero_reg;

  logic [WIDTH:0]   acc_shifted;
  logic [WIDTH-1:0] acc_reduced;
  logic [WIDTH-1:0] acc_next;
  logic             seed_is_zero;
  logic [WIDTH-1:0] seed_fixed;

  // One Horner step: multiply the running product by x, fold x^31 back via h(x),
  // then add the state if the current generator coefficient is set.
  always_comb begin
    acc_shifted  = {acc_reg, 1'b0};
    acc_reduced  = acc_shifted[WIDTH] ? (acc_shifted[WIDTH-1:0] ^ POLY_LOW)
                                      : acc_shifted[WIDTH-1:0];
    acc_next     = acc_reduced ^ (MULT[cnt_reg] ? state_reg : '0);
    seed_is_zero = (seed_in == '0);
    seed_fixed   = seed_is_zero ? WIDTH'(1) : seed_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_reg       <= ST_IDLE;
      state_reg     <= WIDTH'(1);
      acc_reg       <= '0;
      cnt_reg       <= '0;
      rand_out_reg  <= '0;
      out_valid_reg <= 1'b0;
      seed_zero_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      seed_zero_reg <= 1'b0;
      if (seed_load) begin
        // Seeding wins in any state and abandons an in-flight product.
        state_reg     <= seed_fixed;
        seed_zero_reg <= seed_is_zero;
        fsm_reg       <= ST_IDLE;
      end else begin
        case (fsm_reg)
          ST_IDLE: begin
            if (req) begin
              acc_reg <= '0;
              cnt_reg <= CNT_TOP;
              fsm_reg <= ST_MUL;
            end
          end
          default: begin
            acc_reg <= acc_next;
            if (cnt_reg == '0) begin
              state_reg     <= acc_next;
              rand_out_reg  <= acc_next;
              out_valid_reg <= 1'b1;
              fsm_reg       <= ST_IDLE;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign ready     = (fsm_reg == ST_IDLE);
  assign out_valid = out_valid_reg;
  assign rand_out  = rand_out_reg;
  assign seed_zero = seed_zero_reg;

endmodule

// File: tb/tb_gf2_31_prng_seq.sv
// Directed bench for gf2_31_prng_seq: latency, seeding, abort, streaming and async reset.
module tb_gf2_31_prng_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [30:0] seed_in;
  logic        req;
  logic        ready;
  logic        out_valid;
  logic [30:0] rand_out;
  logic        seed_zero;

  int n_tests = 0;
  int n_fail  = 0;

  gf2_31_prng_seq dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .req       (req),
    .ready     (ready),
    .out_valid (out_valid),
    .rand_out  (rand_out),
    .seed_zero (seed_zero)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max_cycles, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
  endtask

  task automatic load_seed(input logic [30:0] s);
    seed_load = 1'b1;
    seed_in   = s;
    tick();
    seed_load = 1'b0;
    seed_in   = '0;
  endtask

  // Single request: checks 31-cycle latency, value, ready and the one-cycle pulse.
  task automatic run_req(input string tag, input logic [30:0] exp);
    int n;
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_valid(40, n);
    $display("[TB] %s: word %h after %0d cycles", tag, rand_out, n);
    check({tag, "_latency"}, 32'(n), 32'd31);
    check({tag, "_value"}, {1'b0, rand_out}, {1'b0, exp});
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    tick();
    check({tag, "_pulse_end"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int n;
    int hits;
    logic [30:0] exp_seq [4];
    exp_seq[0] = 31'd2;
    exp_seq[1] = 31'd4;
    exp_seq[2] = 31'd8;
    exp_seq[3] = 31'd16;

    rst = 1'b1; seed_load = 1'b0; seed_in = '0; req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: reset values, then first product from the reset state 1
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_rand_out", {1'b0, rand_out}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_seed_zero", {31'd0, seed_zero}, 32'd0);
    run_req("t1", 31'h0000_0002);

    // 2: x^30 * x wraps through the reduction polynomial
    load_seed(31'h4000_0000);
    check("t2_seed_zero", {31'd0, seed_zero}, 32'd0);
    run_req("t2", 31'h0000_2109);

    // 3: zero seed is replaced by 1 with a single flag pulse
    load_seed(31'h0);
    check("t3_seed_zero_set", {31'd0, seed_zero}, 32'd1);
    tick();
    check("t3_seed_zero_clr", {31'd0, seed_zero}, 32'd0);
    run_req("t3", 31'h0000_0002);

    // 4: seed_load at the 10th MUL cycle aborts the product
    load_seed(31'h1);
    req = 1'b1;
    tick();
    req = 1'b0;
    check("t4_busy", {31'd0, ready}, 32'd0);
    repeat (9) tick();
    load_seed(31'h5);
    check("t4_abort_no_valid", {31'd0, out_valid}, 32'd0);
    check("t4_abort_ready", {31'd0, ready}, 32'd1);
    check("t4_rand_out_kept", {1'b0, rand_out}, 32'd2);
    hits = 0;
    repeat (40) begin
      tick();
      if (out_valid === 1'b1) hits++;
    end
    check("t4_no_late_valid", 32'(hits), 32'd0);
    run_req("t4", 31'h0000_000A);

    // 5: req held high streams one word every 32 cycles
    load_seed(31'h1);
    req = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      wait_valid(40, n);
      if (k == 3) req = 1'b0;
      $display("[TB] t5 word %0d: %h gap %0d", k, rand_out, (k == 0) ? n : n + 1);
      check($sformatf("t5_gap%0d", k), 32'((k == 0) ? n : n + 1), (k == 0) ? 32'd31 : 32'd32);
      check($sformatf("t5_value%0d", k), {1'b0, rand_out}, {1'b0, exp_seq[k]});
      check($sformatf("t5_ready%0d", k), {31'd0, ready}, 32'd1);
    end
    tick();
    check("t5_stopped", {31'd0, ready}, 32'd1);

    // 6: asynchronous reset between edges while multiplying
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (5) tick();
    check("t6_busy", {31'd0, ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("t6_async_ready", {31'd0, ready}, 32'd1);
    check("t6_async_rand_out", {1'b0, rand_out}, 32'd0);
    check("t6_async_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_req("t6", 31'h0000_0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
